// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the floating-point issue controller.
//   FPU_LAT     cycles from issue to the FP register-file write edge
//   freg_idx_t  FP register index (32 registers)
//   sb_entry_t  one scoreboard slot: {v, rd}
package fpu_pkg;

  localparam int FPU_LAT = 5;

  typedef logic [4:0] freg_idx_t;

  typedef struct packed {
    logic      v;
    freg_idx_t rd;
  } sb_entry_t;

endpackage

// File: rtl/fpu_tag_pipe.sv
// fpu_tag_pipe: LAT-deep shift register of {v, rd} tags, one slot per
// in-flight FP register write. Slot 0 takes the new tag each cycle, slot
// LAT-1 falls off the end when its write lands.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears every slot)
//   load_v        a write was issued this cycle
//   load_rd       destination of that write
//   tag_v         per-slot valid bits
//   tag_rd        per-slot destination indices
//   busy          at least one slot valid
module fpu_tag_pipe
  import fpu_pkg::*;
#(
  parameter int LAT = FPU_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_v,
  input  freg_idx_t             load_rd,
  output logic      [LAT-1:0]   tag_v,
  output freg_idx_t [LAT-1:0]   tag_rd,
  output logic                  busy
);

  sb_entry_t pipe_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0] <= '{v: load_v, rd: load_rd};
      for (int k = 1; k < LAT; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  always_comb begin
    tag_v  = '0;
    tag_rd = '0;
    for (int k = 0; k < LAT; k++) begin
      tag_v[k]  = pipe_q[k].v;
      tag_rd[k] = pipe_q[k].rd;
    end
  end

  assign busy = |tag_v;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue gate in front of the 5-stage FPU. Holds back any
// instruction whose FP sources still have a write in flight, since the FPU
// has no forwarding and no stall of its own.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake for a decoded FP instruction
//   in_rs1, in_rs2            FP source indices
//   in_use_rs1, in_use_rs2    which sources are actually read
//   in_rd, in_wr              FP destination and whether it is written
//   hold                      downstream stall, blocks issue
//   issue                     FPU instruction gate (0 = NOP presented)
//   busy                      an FP write is still in flight
//   stall_cnt                 saturating count of in_valid & ~in_ready cycles
//
// Handshake: an instruction transfers in any cycle where in_valid and
// in_ready are both high; that same cycle issue is high. in_ready does not
// depend on in_valid. While in_valid & ~in_ready upstream keeps the fields
// stable. There is no write-after-write check: all ops share one latency,
// so writes retire in issue order.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT  = FPU_LAT,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  freg_idx_t   in_rs1,
  input  freg_idx_t   in_rs2,
  input  logic        in_use_rs1,
  input  logic        in_use_rs2,
  input  freg_idx_t   in_rd,
  input  logic        in_wr,
  input  logic        hold,
  output logic        issue,
  output logic        busy,
  output logic [31:0] stall_cnt
);

  // Only the low IW bits of an index are significant for NREG registers.
  localparam int IW = $clog2(NREG);

  logic      [LAT-1:0] tag_v;
  freg_idx_t [LAT-1:0] tag_rd;
  logic                hit1;
  logic                hit2;
  logic                hazard;

  fpu_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .load_v  (issue & in_wr),
    .load_rd (in_rd),
    .tag_v   (tag_v),
    .tag_rd  (tag_rd),
    .busy    (busy)
  );

  // f0 is a real register, so no index is exempt from the compare.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (tag_v[k] && (tag_rd[k][IW-1:0] == in_rs1[IW-1:0])) hit1 = 1'b1;
      if (tag_v[k] && (tag_rd[k][IW-1:0] == in_rs2[IW-1:0])) hit2 = 1'b1;
    end
  end

  assign hazard = (in_use_rs1 & hit1) | (in_use_rs2 & hit2);

  // rst gates the handshake directly so issue drops the moment reset is
  // asserted, without waiting for a clock edge.
  assign in_ready = ~hazard & ~hold & ~rst;
  assign issue    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
